// File: rtl/lut_tabla_pkg.sv
// lut_tabla_pkg: shared types and sizing helpers for the programmable truth-table engine
package lut_tabla_pkg;
  typedef enum logic {IDLE, SWEEP} state_t;
  localparam int N_IN_DEF = 4;
  function automatic int table_w(input int n);
    return 1 << n;
  endfunction
  function automatic int acc_w(input int n);
    return n + 1;
  endfunction
endpackage

// File: rtl/lut_tabla_prog_if.sv
// lut_tabla_prog_if: load/eval/sweep bus between stimulus source and truth-table engine
interface lut_tabla_prog_if
  import lut_tabla_pkg::*;
#(parameter int N_IN = N_IN_DEF);
  logic load_valid, load_bit, loaded;
  logic eval_valid, sweep_start, sweep_busy, sweep_done;
  logic y, y_valid;
  logic [N_IN-1:0] in_vec, y_idx;
  logic [acc_w(N_IN)-1:0] ones_count;
  modport master (
    output load_valid, load_bit, eval_valid, in_vec, sweep_start,
    input loaded, sweep_busy, sweep_done, y, y_valid, y_idx, ones_count
  );
  modport slave (
    input load_valid, load_bit, eval_valid, in_vec, sweep_start,
    output loaded, sweep_busy, sweep_done, y, y_valid, y_idx, ones_count
  );
endinterface

// File: rtl/lut_load_shifter.sv
// lut_load_shifter: LSB-first table shift register with frame counter and loaded flag
module lut_load_shifter
  import lut_tabla_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  localparam int TW = table_w(N_IN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift_en,
  input  logic          load_bit,
  output logic [TW-1:0] tbl,
  output logic          loaded
);
  logic [N_IN-1:0] cnt;
  // cnt is exactly N_IN bits, so it wraps to 0 on its own after the TW-th bit
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl    <= '0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (shift_en) begin
      tbl    <= {load_bit, tbl[TW-1:1]};
      cnt    <= cnt + 1'b1;
      loaded <= cnt == '1 ? 1'b1 : cnt == '0 ? 1'b0 : loaded;
    end
  end
endmodule

// File: rtl/lut_tabla_prog.sv
// lut_tabla_prog: serially loaded 2^N_IN-entry truth table with on-demand eval and counted sweep
module lut_tabla_prog
  import lut_tabla_pkg::*;
#(parameter int N_IN = N_IN_DEF) (
  input logic clk,
  input logic reset,
  lut_tabla_prog_if.slave bus
);
  localparam int TW = table_w(N_IN);
  localparam int AW = acc_w(N_IN);
  state_t          state, state_n;
  logic [TW-1:0]   tbl;
  logic [AW-1:0]   acc;
  logic [N_IN-1:0] sw_idx;
  logic            idle, load_go, sweep_go, eval_go, last, emit;
  lut_load_shifter #(.N_IN(N_IN)) u_load (
    .clk      (clk),
    .reset    (reset),
    .shift_en (load_go),
    .load_bit (bus.load_bit),
    .tbl      (tbl),
    .loaded   (bus.loaded)
  );
  // y_idx doubles as the sweep pointer: the next entry is always y_idx+1
  always_comb begin
    idle     = state == IDLE;
    load_go  = idle && bus.load_valid;
    sweep_go = idle && !bus.load_valid && bus.sweep_start && bus.loaded;
    eval_go  = idle && !bus.load_valid && !bus.sweep_start && bus.eval_valid && bus.loaded;
    last     = !idle && bus.y_idx == '1;
    emit     = sweep_go || (!idle && !last);
    sw_idx   = sweep_go ? '0 : bus.y_idx + 1'b1;
    state_n  = sweep_go ? SWEEP : last ? IDLE : state;
  end
  assign bus.sweep_busy = !idle;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.y          <= 1'b0;
      bus.y_valid    <= 1'b0;
      bus.y_idx      <= '0;
      bus.sweep_done <= 1'b0;
      bus.ones_count <= '0;
      acc            <= '0;
    end else begin
      bus.y_valid    <= emit || eval_go;
      bus.sweep_done <= last;
      if (emit) begin
        bus.y     <= tbl[sw_idx];
        bus.y_idx <= sw_idx;
        acc       <= (sweep_go ? '0 : acc) + AW'(tbl[sw_idx]);
      end else if (eval_go) begin
        bus.y     <= tbl[bus.in_vec];
        bus.y_idx <= bus.in_vec;
      end
      if (last) bus.ones_count <= acc;
    end
  end
endmodule

// File: doc/lut_tabla_prog.md
# lut_tabla_prog

Programmable N-input truth-table engine: a 2^N-entry truth table is loaded serially, then either evaluated on demand for an input vector or swept over all input combinations with a minterm count. It generalises the fixed per-table combinational functions used in the lab exercises. It sits between a stimulus/register source and an output display or checker, and replaces hand-coded gate-level and behavioral variants.

## Interface
- N_IN, 4, number of table inputs (legal 2..6); TABLE_W = 2**N_IN entries
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  one table bit presented this cycle
- load_bit  in  1  table bit, LSB-first (first bit sent = output for input 0)
- loaded  out  1  a full TABLE_W-bit frame has been received
- eval_valid  in  1  evaluate in_vec this cycle
- in_vec  in  N_IN  input combination to evaluate
- sweep_start  in  1  request exhaustive sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- y  out  1  registered table output
- y_valid  out  1  y/y_idx valid this cycle
- y_idx  out  N_IN  input combination that produced y
- ones_count  out  N_IN+1  minterm count from last completed sweep

## Operation
- FSM states: IDLE, SWEEP. Reset -> IDLE.
- Reset values: table=0, load count=0, loaded=0, y=0, y_valid=0, y_idx=0, sweep_busy=0, sweep_done=0, ones_count=0.
- Load (IDLE only): table <= {load_bit, table[TABLE_W-1:1]}; count increments. First bit of a frame clears loaded. On the TABLE_W-th bit: loaded=1, count wraps to 0. Ignored in SWEEP (count unchanged).
- Eval (IDLE, loaded=1): next cycle y=table[in_vec], y_idx=in_vec, y_valid=1. Ignored when loaded=0 or in SWEEP.
- Sweep start (IDLE, loaded=1): accumulator cleared, idx=0, -> SWEEP. Ignored when loaded=0 or already in SWEEP.
- SWEEP: each cycle emit y=table[idx], y_idx=idx, y_valid=1; accumulator += table[idx]; idx++. After idx=TABLE_W-1 emitted -> IDLE, sweep_done=1 one cycle, ones_count updated; ones_count holds until next sweep completes.
- Same-cycle priority in IDLE: load_valid > sweep_start > eval_valid; losers dropped, not queued.
- Accumulator and ones_count are N_IN+1 bits; all-ones table gives TABLE_W exactly, no overflow.
- Reset mid-load or mid-sweep: all state returns to reset values next edge; partial frame lost, ones_count=0.

## Timing
- Eval latency: 1 cycle (request at t, y_valid at t+1).
- Sweep: start at t; y_valid/sweep_busy high t+1..t+TABLE_W with y_idx=0..TABLE_W-1; sweep_done=1 and ones_count valid at t+TABLE_W+1, sweep_busy=0 then.
- sweep_start sampled in the sweep_done cycle is accepted (back-to-back sweeps, one gap cycle).
- Full load takes TABLE_W cycles of load_valid; loaded rises the cycle after the last bit.
- y_valid is low in every cycle without an accepted eval or active sweep; y and y_idx hold last values.

## Structure
- Package lut_tabla_pkg: state enum (IDLE, SWEEP), function computing TABLE_W from N_IN, count width constant.
- Sub-module lut_load_shifter: shift register plus frame counter and loaded flag; top holds FSM, eval mux, sweep counter, accumulator.

## Test plan
- N_IN=4, reset, load 0xA5C3 LSB-first (16 bits) -> loaded=1 the cycle after bit 16; loaded=0 during bits 1-16.
- Eval in_vec=0, 2, 15 -> y=1, 0, 1 with y_valid one cycle later and y_idx matching.
- sweep_start after 0xA5C3 load -> y sequence equals table bits 0..15 on 16 consecutive cycles, sweep_done at t+17, ones_count=8; repeat with 0xFFFF -> ones_count=16.
- eval_valid, load_valid, sweep_start during SWEEP -> all ignored, table and y_idx sequence unchanged; sweep_start with eval_valid in IDLE -> sweep runs, no eval result.
- Reset asserted at y_idx=7 of a sweep -> next cycle all outputs at reset values, loaded=0; eval before reload produces no y_valid.
- N_IN=2, load 4'b0110, sweep back-to-back (start in sweep_done cycle) -> two sweeps, ones_count=2 each, one-cycle gap.
